preg_free_list: RTL



---
 rtl/preg_free_list.sv | 96 +++++++++
 1 files changed

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - circular free list of physical registers with speculative and architectural heads
// Flush recovery copies the architectural head into the speculative head; no checkpoints are kept.
package buffer_pkgs;
  localparam int PREG_W = 6;
endpackage

module preg_free_list
  import buffer_pkgs::*;
#(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_req_i,
  output logic              alloc_valid_o,
  output logic [PREG_W-1:0] alloc_preg_o,
  input  logic              commit_retire_i,
  input  logic              commit_free_valid_i,
  input  logic [PREG_W-1:0] commit_free_preg_i,
  input  logic              flush_i,
  output logic [PREG_W:0]   free_count_o,
  output logic              err_o
);

  typedef logic [PREG_W:0]   ptr_t;
  typedef logic [PREG_W-1:0] preg_t;

  preg_t ring_q [NUM_PREGS];
  ptr_t  spec_head_q;
  ptr_t  arch_head_q;
  ptr_t  tail_q;
  logic  err_q;

  ptr_t  occupancy;
  ptr_t  spec_head_d;
  ptr_t  arch_head_d;
  ptr_t  tail_d;
  logic  alloc_fire;
  logic  retire_ok;
  logic  retire_bad;
  logic  release_ok;
  logic  release_bad;

  // Full and empty differ only in the wrap bit, so both counts use the full-width difference.
  assign free_count_o  = tail_q - spec_head_q;
  assign occupancy     = tail_q - arch_head_q;
  assign alloc_valid_o = (free_count_o != '0) && !flush_i;
  assign alloc_preg_o  = ring_q[spec_head_q[PREG_W-1:0]];
  assign err_o         = err_q;

  assign alloc_fire  = alloc_req_i && alloc_valid_o;
  assign retire_bad  = commit_retire_i && (arch_head_q == spec_head_q);
  assign retire_ok   = commit_retire_i && !retire_bad;
  assign release_bad = commit_free_valid_i && (occupancy == ptr_t'(NUM_PREGS));
  assign release_ok  = commit_free_valid_i && !release_bad;

  always_comb begin
    arch_head_d = arch_head_q;
    spec_head_d = spec_head_q;
    tail_d      = tail_q;
    if (retire_ok) begin
      arch_head_d = arch_head_q + ptr_t'(1);
    end
    // A retire in the flush cycle is already folded into arch_head_d.
    if (flush_i) begin
      spec_head_d = arch_head_d;
    end else if (alloc_fire) begin
      spec_head_d = spec_head_q + ptr_t'(1);
    end
    if (release_ok) begin
      tail_d = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        ring_q[i] <= (i < NUM_PREGS - NUM_ARCH) ? preg_t'(NUM_ARCH + i) : '0;
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= ptr_t'(NUM_PREGS - NUM_ARCH);
      err_q       <= 1'b0;
    end else begin
      if (release_ok) begin
        ring_q[tail_q[PREG_W-1:0]] <= commit_free_preg_i;
      end
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      err_q       <= err_q | retire_bad | release_bad;
    end
  end

endmodule
